// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: default width, counter width
// and bit positions of the control-to-datapath action strobes.
package mult_pkg;

    localparam int unsigned MULT_N = 8;
    localparam int unsigned CNT_W  = $clog2(MULT_N);

    localparam int unsigned ACT_CLINICIO = 0;
    localparam int unsigned ACT_CLC      = 1;
    localparam int unsigned ACT_WC       = 2;
    localparam int unsigned ACT_WA       = 3;
    localparam int unsigned ACT_WSUMH    = 4;
    localparam int unsigned ACT_WSUML    = 5;
    localparam int unsigned ACT_SHRSUM   = 6;
    localparam int unsigned ACT_UPCONT   = 7;
    localparam int unsigned ACT_FIN      = 8;
    localparam int unsigned NUM_ACT      = 9;

    typedef logic [NUM_ACT-1:0] act_t;

endpackage

// File: rtl/mult_datapath_if.sv
// Control <-> datapath bundle: operands and action strobes one way, status and result back.
interface mult_datapath_if
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
);
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           clinicio;
    logic           clc;
    logic           wc;
    logic           wa;
    logic           wsumh;
    logic           wsuml;
    logic           shrsum;
    logic           upcont;
    logic           fin;
    logic           SUML0;
    logic           cycont;
    logic [2*N-1:0] product;
    logic           done;

    modport master (
        output a, b, clinicio, clc, wc, wa, wsumh, wsuml, shrsum, upcont, fin,
        input  SUML0, cycont, product, done
    );

    modport slave (
        input  a, b, clinicio, clc, wc, wa, wsumh, wsuml, shrsum, upcont, fin,
        output SUML0, cycont, product, done
    );
endinterface

// File: rtl/mult_iter_counter.sv
// Iteration counter: synchronous clear, wrapping increment, terminal-count decode
// taken from the pre-increment value.
module mult_iter_counter
    import mult_pkg::*;
#(
    parameter int unsigned N    = MULT_N,
    parameter int unsigned CntW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clr,
    input  logic            i_inc,
    output logic [CntW-1:0] o_cnt,
    output logic            o_last
);
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;

    assign o_last = (r_cnt == CntW'(N - 1));
    assign o_cnt  = r_cnt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc) begin
            w_cnt_nxt = o_last ? '0 : r_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: executes control strobes on A, {C,SUMH,SUML},
// the iteration counter and the held result register.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic         clk,
    input  logic         reset,
    mult_datapath_if.slave bus
);
    localparam int unsigned CntW = $clog2(N);

    act_t            w_act;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_sumh;
    logic [N-1:0]    r_suml;
    logic            r_c;
    logic [2*N-1:0]  r_product;
    logic            r_done;
    logic [N:0]      w_add;
    logic [N-1:0]    w_sumh_nxt;
    logic [N-1:0]    w_suml_nxt;
    logic            w_c_nxt;
    logic            w_shift;
    logic [CntW-1:0] w_cnt;

    assign w_act[ACT_CLINICIO] = bus.clinicio;
    assign w_act[ACT_CLC]      = bus.clc;
    assign w_act[ACT_WC]       = bus.wc;
    assign w_act[ACT_WA]       = bus.wa;
    assign w_act[ACT_WSUMH]    = bus.wsumh;
    assign w_act[ACT_WSUML]    = bus.wsuml;
    assign w_act[ACT_SHRSUM]   = bus.shrsum;
    assign w_act[ACT_UPCONT]   = bus.upcont;
    assign w_act[ACT_FIN]      = bus.fin;

    assign w_add   = {1'b0, r_a} + {1'b0, r_sumh};
    // An add in the same cycle suppresses the shift on every part of {C,SUMH,SUML}.
    assign w_shift = w_act[ACT_SHRSUM] && !w_act[ACT_WSUMH];

    always_comb begin
        w_sumh_nxt = r_sumh;
        w_suml_nxt = r_suml;
        w_c_nxt    = r_c;

        if (w_act[ACT_WSUML]) begin
            w_suml_nxt = bus.b;
        end else if (w_shift) begin
            w_suml_nxt = {r_sumh[0], r_suml[N-1:1]};
        end

        if (w_act[ACT_CLINICIO]) begin
            w_sumh_nxt = '0;
        end else if (w_act[ACT_WSUMH]) begin
            w_sumh_nxt = w_add[N-1:0];
        end else if (w_shift) begin
            w_sumh_nxt = {r_c, r_sumh[N-1:1]};
        end

        if (w_act[ACT_CLINICIO]) begin
            w_c_nxt = 1'b0;
        end else if (w_act[ACT_WC]) begin
            w_c_nxt = w_add[N];
        end else if (w_act[ACT_CLC] || w_shift) begin
            w_c_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a       <= '0;
            r_sumh    <= '0;
            r_suml    <= '0;
            r_c       <= 1'b0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_act[ACT_WA]) begin
                r_a <= bus.a;
            end
            r_sumh <= w_sumh_nxt;
            r_suml <= w_suml_nxt;
            r_c    <= w_c_nxt;
            if (w_act[ACT_FIN]) begin
                r_product <= {r_sumh, r_suml};
            end
            if (w_act[ACT_CLINICIO]) begin
                r_done <= 1'b0;
            end else if (w_act[ACT_FIN]) begin
                r_done <= 1'b1;
            end
        end
    end

    mult_iter_counter #(
        .N    (N),
        .CntW (CntW)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_act[ACT_CLINICIO]),
        .i_inc  (w_act[ACT_UPCONT]),
        .o_cnt  (w_cnt),
        .o_last (bus.cycont)
    );

    assign bus.SUML0   = r_suml[0];
    assign bus.product = r_product;
    assign bus.done    = r_done;

    // Counter value is only observed by the terminal-count decode here.
    logic w_unused;
    assign w_unused = ^w_cnt;
endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath (N=8): full multiplications, counter wrap,
// strobe collisions and asynchronous reset mid-operation.
module tb_mult_datapath;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mult_datapath_if #(.N(8)) bus ();

    mult_datapath #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.clinicio = 1'b0; bus.clc = 1'b0; bus.wc = 1'b0; bus.wa = 1'b0;
        bus.wsumh = 1'b0; bus.wsuml = 1'b0; bus.shrsum = 1'b0; bus.upcont = 1'b0;
        bus.fin = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_init(input logic [7:0] ta, input logic [7:0] tb_v);
        bus.a = ta; bus.b = tb_v;
        bus.clinicio = 1'b1; bus.wa = 1'b1; bus.wsuml = 1'b1;
        tick();
    endtask

    // One add-or-clear cycle followed by one shift cycle, as u_control would issue them.
    task automatic do_iter(input int i, input logic [7:0] tb_v);
        logic bit_i;
        bit_i = tb_v[i];
        chk($sformatf("suml0_it%0d", i), 32'(bus.SUML0), 32'(bit_i));
        if (bit_i) begin
            bus.wsumh = 1'b1; bus.wc = 1'b1;
        end else begin
            bus.clc = 1'b1;
        end
        tick();
        chk($sformatf("cycont_it%0d", i), 32'(bus.cycont), 32'(i == 7));
        bus.shrsum = 1'b1; bus.upcont = 1'b1;
        tick();
    endtask

    task automatic run_mult(input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic [15:0] exp_p, input logic [15:0] old_p);
        do_init(ta, tb_v);
        chk("init_done", 32'(bus.done), 32'd0);
        chk("init_prod_hold", 32'(bus.product), 32'(old_p));
        for (int i = 0; i < 8; i++) begin
            do_iter(i, tb_v);
        end
        chk("pre_fin_prod_hold", 32'(bus.product), 32'(old_p));
        chk("post_iter_cycont", 32'(bus.cycont), 32'd0);
        bus.fin = 1'b1;
        tick();
        chk($sformatf("product_%0d_x_%0d", ta, tb_v), 32'(bus.product), 32'(exp_p));
        chk("fin_done", 32'(bus.done), 32'd1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.a = '0;
        bus.b = '0;
        idle();
        reset = 1'b0;
        #12;
        chk("rst_product", 32'(bus.product), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_suml0", 32'(bus.SUML0), 32'd0);
        chk("rst_cycont", 32'(bus.cycont), 32'd0);
        reset = 1'b1;
        tick();

        // 13 * 11 = 143
        run_mult(8'd13, 8'd11, 16'h008F, 16'h0000);

        // clinicio clears done but keeps the previous product until the next fin
        bus.clinicio = 1'b1;
        tick();
        chk("clr_done", 32'(bus.done), 32'd0);
        chk("clr_prod_hold", 32'(bus.product), 32'h008F);

        // 255 * 255 exercises the carry into SUMH[7]
        run_mult(8'd255, 8'd255, 16'hFE01, 16'h008F);

        run_mult(8'd0, 8'hA5, 16'h0000, 16'hFE01);
        run_mult(8'h5A, 8'd0, 16'h0000, 16'h0000);

        // counter: wrap after 8 pulses, terminal count at 7
        bus.clinicio = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cnt_val%0d", k), 32'(dut.u_cnt.r_cnt), k);
            chk($sformatf("cnt_cycont%0d", k), 32'(bus.cycont), 32'(k == 7));
            bus.upcont = 1'b1;
            tick();
        end
        chk("cnt_wrap", 32'(dut.u_cnt.r_cnt), 32'd0);
        bus.upcont = 1'b1;
        tick();
        bus.upcont = 1'b1;
        tick();
        chk("cnt_two", 32'(dut.u_cnt.r_cnt), 32'd2);
        bus.clinicio = 1'b1; bus.upcont = 1'b1;
        tick();
        chk("cnt_clr_wins", 32'(dut.u_cnt.r_cnt), 32'd0);

        // wsumh + shrsum together: add wins, no shift anywhere
        do_init(8'd3, 8'd4);
        bus.wsumh = 1'b1; bus.shrsum = 1'b1;
        tick();
        chk("coll_sumh", 32'(dut.r_sumh), 32'd3);
        chk("coll_suml", 32'(dut.r_suml), 32'd4);
        chk("coll_c", 32'(dut.r_c), 32'd0);
        // fin + clinicio: product updates, done stays low
        bus.fin = 1'b1; bus.clinicio = 1'b1;
        tick();
        chk("fin_clr_product", 32'(bus.product), 32'h0304);
        chk("fin_clr_done", 32'(bus.done), 32'd0);
        chk("fin_clr_sumh", 32'(dut.r_sumh), 32'd0);

        // asynchronous reset after 3 iterations, between clock edges
        do_init(8'd200, 8'd201);
        for (int i = 0; i < 3; i++) begin
            do_iter(i, 8'd201);
        end
        #3;
        reset = 1'b0;
        #1;
        chk("arst_sumh", 32'(dut.r_sumh), 32'd0);
        chk("arst_suml", 32'(dut.r_suml), 32'd0);
        chk("arst_c", 32'(dut.r_c), 32'd0);
        chk("arst_cnt", 32'(dut.u_cnt.r_cnt), 32'd0);
        chk("arst_product", 32'(bus.product), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        #2;
        reset = 1'b1;
        run_mult(8'd7, 8'd9, 16'd63, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
